up_sample_seq_ctrl: RTL and testbench

Sequencing controller for the up_sample pipeline. It generates the write/read enables and `[2:0]` loop-index control vectors for the input-stencil buffer (64×64) and the nearest-neighbor stencil buffer (128×128). It runs one frame as three phases: load, compute, and output. Pixel data never passes through this block; it wires directly between the streams and the buffers.

---
 rtl/up_sample_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_up_sample_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/up_sample_seq_ctrl.sv
// Sequencing controller for the 2x nearest-neighbour up_sample pipeline.
// Drives buffer enables and {col,row,0} index vectors through load, compute and output phases.
module up_sample_seq_ctrl #(
  parameter int unsigned IN_W   = 64,
  parameter int unsigned IN_H   = 64,
  parameter int unsigned CW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 flush,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 in_wen,
  output logic [2:0][CW-1:0]   in_wr_ctrl_vars,
  output logic                 nn_ren,
  output logic [2:0][CW-1:0]   nn_rd_ctrl_vars,
  output logic                 nn_wen,
  output logic [2:0][CW-1:0]   nn_wr_ctrl_vars,
  output logic                 out_ren,
  output logic [2:0][CW-1:0]   out_rd_ctrl_vars,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_OUTPUT
  } state_t;

  localparam logic [CW-1:0] LD_COL_LAST = CW'(IN_W - 1);
  localparam logic [CW-1:0] LD_ROW_LAST = CW'(IN_H - 1);
  localparam logic [CW-1:0] UP_COL_LAST = CW'(2 * IN_W - 1);
  localparam logic [CW-1:0] UP_ROW_LAST = CW'(2 * IN_H - 1);
  localparam logic [7:0]    DRAIN_LAST  = 8'(RD_LAT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic [CW-1:0]      w_row_nxt;
  logic [CW-1:0]      w_col_nxt;
  logic [CW-1:0]      w_row_term;
  logic [CW-1:0]      w_col_term;
  logic               w_last;
  logic               w_accept;
  logic               w_adv;
  logic [7:0]         r_drain;
  logic               r_out_valid;
  logic               r_done;
  logic [RD_LAT-1:0]  r_pipe_en;
  logic [2:0][CW-1:0] r_pipe_idx [RD_LAT];
  logic [2:0][CW-1:0] w_cur;
  logic [2:0][CW-1:0] w_nxt;

  // One shared row/col counter serves all phases; the terminal values depend on the phase.
  always_comb begin
    w_col_term = (r_state == S_LOAD) ? LD_COL_LAST : UP_COL_LAST;
    w_row_term = (r_state == S_LOAD) ? LD_ROW_LAST : UP_ROW_LAST;
    w_last     = (r_row == w_row_term) && (r_col == w_col_term);
    if (r_col == w_col_term) begin
      w_col_nxt = '0;
      w_row_nxt = r_row + 1'b1;
    end else begin
      w_col_nxt = r_col + 1'b1;
      w_row_nxt = r_row;
    end
    w_accept = r_out_valid & out_ready;
    w_adv    = ((r_state == S_LOAD) && in_valid) ||
               (r_state == S_COMPUTE) ||
               ((r_state == S_OUTPUT) && w_accept);
    w_next   = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD;
      S_LOAD:    if (in_valid && w_last) w_next = S_COMPUTE;
      S_COMPUTE: if (w_last) w_next = S_DRAIN;
      S_DRAIN:   if (r_drain == DRAIN_LAST) w_next = S_OUTPUT;
      S_OUTPUT:  if (w_accept && w_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_cur = {r_col, r_row, {CW{1'b0}}};
  assign w_nxt = {w_col_nxt, w_row_nxt, {CW{1'b0}}};

  assign busy            = (r_state != S_IDLE);
  assign in_ready        = (r_state == S_LOAD);
  assign in_wen          = in_valid & in_ready;
  assign in_wr_ctrl_vars = in_ready ? w_cur : '0;
  assign nn_ren          = (r_state == S_COMPUTE);
  assign nn_rd_ctrl_vars = nn_ren ? w_cur : '0;
  assign nn_wen          = r_pipe_en[RD_LAT-1];
  assign nn_wr_ctrl_vars = r_pipe_idx[RD_LAT-1];
  assign out_ren         = (r_state == S_OUTPUT);
  assign out_valid       = r_out_valid;
  assign done            = r_done;

  // Lookahead address keeps the registered buffer read aligned with the pixel presented next.
  assign out_rd_ctrl_vars = !out_ren ? '0 :
                            (w_accept && !w_last) ? w_nxt : w_cur;

  always_ff @(posedge clk) begin
    if (flush) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_drain     <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_adv) begin
        r_row <= w_row_nxt;
        r_col <= w_col_nxt;
      end
      r_drain     <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
      r_out_valid <= (r_state == S_OUTPUT) && !(w_accept && w_last);
      r_done      <= (r_state == S_OUTPUT) && w_accept && w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      r_pipe_en <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_pipe_en[0]  <= nn_ren;
      r_pipe_idx[0] <= nn_rd_ctrl_vars;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe_en[i]  <= r_pipe_en[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

endmodule

// File: tb/tb_up_sample_seq_ctrl.sv
// Directed bench for up_sample_seq_ctrl on a reduced 16x8 frame with modelled buffers.
// Every presented pixel is compared against base + in(Y>>1, X>>1) of a raster ramp.
module tb_up_sample_seq_ctrl;

  localparam int TW = 16;
  localparam int TH = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic flush = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, in_ready, in_wen, nn_ren, nn_wen, out_ren, out_valid;
  logic [2:0][CW-1:0] in_wr_ctrl_vars, nn_rd_ctrl_vars, nn_wr_ctrl_vars, out_rd_ctrl_vars;

  up_sample_seq_ctrl #(.IN_W(TW), .IN_H(TH), .CW(CW), .RD_LAT(1)) dut (
    .clk(clk), .flush(flush), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_wr_ctrl_vars(in_wr_ctrl_vars), .nn_ren(nn_ren), .nn_rd_ctrl_vars(nn_rd_ctrl_vars),
    .nn_wen(nn_wen), .nn_wr_ctrl_vars(nn_wr_ctrl_vars), .out_ren(out_ren),
    .out_rd_ctrl_vars(out_rd_ctrl_vars), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int base = 0;
  int k = 0;
  int acc_cnt = 0, done_cnt = 0, inw_cnt = 0, nnw_cnt = 0;
  int a0, d0, i0, w0;

  int inbuf [TW*TH];
  int nnbuf [4*TW*TH];
  int n_wr = 0;
  int nn_rd_q = 0;
  int out_data = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] cv(input int r, input int c);
    return {16'h0, 16'(c), 16'(r), 16'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done();
    while (!done && cyc < 6000) step();
  endtask

  task automatic reset_chk();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_in_wen", 64'(in_wen), 64'd0);
    chk("rst_nn_ren", 64'(nn_ren), 64'd0);
    chk("rst_nn_wen", 64'(nn_wen), 64'd0);
    chk("rst_out_ren", 64'(out_ren), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_wr", 64'(in_wr_ctrl_vars), 64'd0);
    chk("rst_nn_rd", 64'(nn_rd_ctrl_vars), 64'd0);
    chk("rst_nn_wr", 64'(nn_wr_ctrl_vars), 64'd0);
    chk("rst_out_rd", 64'(out_rd_ctrl_vars), 64'd0);
  endtask

  // Buffer models: input buffer, nn buffer (registered read of in(Y>>1,X>>1)), output read.
  always @(posedge clk) begin
    if (!busy) n_wr <= 0;
    else if (in_wen) n_wr <= n_wr + 1;
    if (in_wen)
      inbuf[(int'(in_wr_ctrl_vars[1]) * TW + int'(in_wr_ctrl_vars[2])) % (TW*TH)] <= base + n_wr;
    if (nn_ren)
      nn_rd_q <= inbuf[((int'(nn_rd_ctrl_vars[1]) >> 1) * TW + (int'(nn_rd_ctrl_vars[2]) >> 1)) % (TW*TH)];
    if (nn_wen)
      nnbuf[(int'(nn_wr_ctrl_vars[1]) * 2 * TW + int'(nn_wr_ctrl_vars[2])) % (4*TW*TH)] <= nn_rd_q;
    if (out_ren)
      out_data <= nnbuf[(int'(out_rd_ctrl_vars[1]) * 2 * TW + int'(out_rd_ctrl_vars[2])) % (4*TW*TH)];
  end

  always @(negedge clk) begin
    int e;
    if (done) done_cnt++;
    if (in_wen) inw_cnt++;
    if (nn_wen) nnw_cnt++;
    if (out_valid) begin
      e = base + TW * ((k / (2*TW)) >> 1) + ((k % (2*TW)) >> 1);
      chk("pixel", 64'(out_data), 64'(e));
      if (out_ready) begin
        k++;
        acc_cnt++;
      end
    end else if (!busy) begin
      k = 0;
    end
  end

  task automatic snap();
    a0 = acc_cnt; d0 = done_cnt; i0 = inw_cnt; w0 = nnw_cnt;
  endtask

  initial begin
    // Reset with random stimulus on the other inputs.
    flush = 1'b1;
    start = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    step();
    reset_chk();
    start = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    step();
    reset_chk();
    flush = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Frame A: continuous stream, detailed phase checks, start pulses ignored.
    base = 0; snap();
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    chk("A_busy", 64'(busy), 64'd1);
    chk("A_in_ready", 64'(in_ready), 64'd1);
    chk("A_in_wen", 64'(in_wen), 64'd1);
    chk("A_in_wr0", 64'(in_wr_ctrl_vars), cv(0, 0));
    step();
    chk("A_in_wr1", 64'(in_wr_ctrl_vars), cv(0, 1));
    start = 1'b1; step(); start = 1'b0;
    chk("A_in_wr2", 64'(in_wr_ctrl_vars), cv(0, 2));
    while (in_ready && cyc < 3000) step();
    chk("A_load_len", 64'(cyc), 64'd129);
    chk("A_nn_ren", 64'(nn_ren), 64'd1);
    chk("A_nn_rd0", 64'(nn_rd_ctrl_vars), cv(0, 0));
    chk("A_nn_wen0", 64'(nn_wen), 64'd0);
    step();
    chk("A_nn_wen1", 64'(nn_wen), 64'd1);
    chk("A_nn_wr0", 64'(nn_wr_ctrl_vars), cv(0, 0));
    chk("A_nn_rd1", 64'(nn_rd_ctrl_vars), cv(0, 1));
    while (cyc < 160) step();
    chk("A_nn_rd31", 64'(nn_rd_ctrl_vars), cv(0, 31));
    step();
    chk("A_nn_rd_wrap", 64'(nn_rd_ctrl_vars), cv(1, 0));
    while (nn_ren && cyc < 3000) step();
    chk("A_drain_at", 64'(cyc), 64'd641);
    chk("A_drain_nn_wen", 64'(nn_wen), 64'd1);
    chk("A_drain_nn_wr", 64'(nn_wr_ctrl_vars), cv(15, 31));
    chk("A_drain_out_ren", 64'(out_ren), 64'd0);
    step();
    chk("A_out_ren", 64'(out_ren), 64'd1);
    chk("A_out_valid0", 64'(out_valid), 64'd0);
    chk("A_out_rd0", 64'(out_rd_ctrl_vars), cv(0, 0));
    chk("A_nn_wen_off", 64'(nn_wen), 64'd0);
    step();
    chk("A_out_valid1", 64'(out_valid), 64'd1);
    chk("A_out_rd_look", 64'(out_rd_ctrl_vars), cv(0, 1));
    start = 1'b1; step(); start = 1'b0;
    wait_done();
    chk("A_frame_len", 64'(cyc), 64'd1155);
    chk("A_done_busy", 64'(busy), 64'd0);
    chk("A_done_valid", 64'(out_valid), 64'd0);
    chk("A_accepts", 64'(acc_cnt - a0), 64'd512);
    step();
    chk("A_done_width", 64'(done), 64'd0);
    chk("A_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("A_in_wen_cnt", 64'(inw_cnt - i0), 64'd128);
    chk("A_nn_wen_cnt", 64'(nnw_cnt - w0), 64'd512);

    // Frame B: in_valid toggling 1,0,1,0 and a 5-cycle stall at pixel (0,3).
    base = 1000; snap();
    cyc = 0; in_valid = 1'b1; start = 1'b1; step(); start = 1'b0;
    while (in_ready && cyc < 3000) begin
      in_valid = cyc[0];
      #1;
      chk("B_in_wen_gap", 64'(in_wen), 64'(in_valid));
      step();
    end
    in_valid = 1'b1;
    chk("B_load_len", 64'(cyc), 64'd256);
    while (!(out_valid && k == 3) && cyc < 3000) step();
    out_ready = 1'b0;
    repeat (5) begin
      step();
      chk("B_stall_valid", 64'(out_valid), 64'd1);
      chk("B_stall_rd", 64'(out_rd_ctrl_vars), cv(0, 3));
    end
    out_ready = 1'b1;
    wait_done();
    chk("B_frame_len", 64'(cyc), 64'd1287);
    chk("B_accepts", 64'(acc_cnt - a0), 64'd512);
    step();
    chk("B_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("B_in_wen_cnt", 64'(inw_cnt - i0), 64'd128);

    // Frame C: flush in the middle of COMPUTE at index 300.
    base = 2000; snap();
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    while (in_ready && cyc < 3000) step();
    while (cyc < 129 + 300) step();
    chk("C_nn_rd300", 64'(nn_rd_ctrl_vars), cv(9, 12));
    flush = 1'b1; step(); flush = 1'b0;
    chk("C_busy", 64'(busy), 64'd0);
    chk("C_nn_wen", 64'(nn_wen), 64'd0);
    chk("C_nn_ren", 64'(nn_ren), 64'd0);
    chk("C_nn_wr", 64'(nn_wr_ctrl_vars), 64'd0);
    step();
    chk("C_nn_wen2", 64'(nn_wen), 64'd0);
    chk("C_done_cnt", 64'(done_cnt - d0), 64'd0);

    // Frame D: clean frame after the flush.
    base = 3000; snap();
    cyc = 0; start = 1'b1; step(); start = 1'b0;
    wait_done();
    chk("D_frame_len", 64'(cyc), 64'd1155);
    chk("D_accepts", 64'(acc_cnt - a0), 64'd512);
    step();
    chk("D_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("D_nn_wen_cnt", 64'(nnw_cnt - w0), 64'd512);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
